adder_tree_pipe: RTL

//  Parametrised successor to the two-input sequential adder: a pipelined N-input reduction adder tree.

---
 rtl/adder_tree_pipe.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/adder_tree_pipe.sv
// Pipelined N-input reduction adder tree with valid/ready handshake and full-pipeline backpressure.
// Optional feature macro: ADDER_TREE_ACC_EN (adds an i_last-delimited accumulate stage after the tree).
module adder_tree_pipe #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_INPUT  = 4,
  parameter bit          SIGNED     = 1'b0,
  parameter int unsigned ACC_WIDTH  = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_INPUT-1:0]              i_valid,
  input  logic [NUM_INPUT*DATA_WIDTH-1:0]   i_data_bus,
  output logic                              i_ready,
`ifdef ADDER_TREE_ACC_EN
  input  logic                              i_last,
  output logic [ACC_WIDTH-1:0]              o_data_bus,
`else
  output logic [DATA_WIDTH+$clog2(NUM_INPUT)-1:0] o_data_bus,
`endif
  output logic                              o_valid,
  input  logic                              o_ready,
  input  logic                              i_en
);

  localparam int unsigned CLOG      = $clog2(NUM_INPUT);
  localparam int unsigned LEVELS    = (NUM_INPUT == 1) ? 1 : CLOG;
  localparam int unsigned SUM_WIDTH = DATA_WIDTH + CLOG;
  localparam int unsigned PAD       = 1 << LEVELS;
  localparam int unsigned NODES     = PAD - 1;
  localparam int unsigned TREE_SZ   = 2 * PAD - 1;

  logic                 stall;
  logic                 adv;
  logic                 accept;
  logic [SUM_WIDTH-1:0] tree_c [TREE_SZ];
  logic [SUM_WIDTH-1:0] node_q [NODES];
  logic [SUM_WIDTH-1:0] node_d [NODES];
  logic [LEVELS-1:0]    vld_q;
  logic [LEVELS-1:0]    vld_d;

  assign stall   = o_valid & ~o_ready;
  assign adv     = i_en & ~stall & ~rst;
  assign i_ready = adv;
  assign accept  = adv & (&i_valid);

  // Heap-ordered view: [0..NODES-1] are registered sums (root at 0), the rest are extended operands.
  always_comb begin
    logic signed [DATA_WIDTH-1:0] op_s;
    for (int unsigned i = 0; i < TREE_SZ; i++) begin
      tree_c[i] = '0;
    end
    for (int unsigned i = 0; i < NODES; i++) begin
      tree_c[i] = node_q[i];
    end
    op_s = '0;
    if (accept) begin
      for (int unsigned k = 0; k < NUM_INPUT; k++) begin
        op_s = i_data_bus[k*DATA_WIDTH +: DATA_WIDTH];
        if (SIGNED) begin
          tree_c[NODES + k] = SUM_WIDTH'(op_s);
        end else begin
          tree_c[NODES + k] = SUM_WIDTH'(i_data_bus[k*DATA_WIDTH +: DATA_WIDTH]);
        end
      end
    end
  end

  // Every level shifts together on adv; a bubble carries zero data through the tree.
  always_comb begin
    node_d = node_q;
    vld_d  = vld_q;
    if (adv) begin
      for (int unsigned i = 0; i < NODES; i++) begin
        node_d[i] = tree_c[2*i + 1] + tree_c[2*i + 2];
      end
      vld_d[0] = accept;
      for (int unsigned l = 1; l < LEVELS; l++) begin
        vld_d[l] = vld_q[l-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NODES; i++) begin
        node_q[i] <= '0;
      end
      vld_q <= '0;
    end else begin
      node_q <= node_d;
      vld_q  <= vld_d;
    end
  end

`ifdef ADDER_TREE_ACC_EN
  logic [LEVELS-1:0]          last_q;
  logic [LEVELS-1:0]          last_d;
  logic [ACC_WIDTH-1:0]       acc_q;
  logic [ACC_WIDTH-1:0]       acc_d;
  logic [ACC_WIDTH-1:0]       out_q;
  logic [ACC_WIDTH-1:0]       out_d;
  logic                       ov_q;
  logic                       ov_d;
  logic [ACC_WIDTH-1:0]       root_ext;
  logic [ACC_WIDTH-1:0]       acc_sum;
  logic signed [SUM_WIDTH-1:0] root_s;

  assign root_s     = node_q[0];
  assign root_ext   = SIGNED ? ACC_WIDTH'(root_s) : ACC_WIDTH'(node_q[0]);
  assign acc_sum    = acc_q + root_ext;
  assign o_valid    = ov_q;
  assign o_data_bus = out_q;

  // i_last rides alongside the tree valids; the group closes when it reaches the accumulator.
  always_comb begin
    last_d = last_q;
    acc_d  = acc_q;
    out_d  = out_q;
    ov_d   = ov_q;
    if (adv) begin
      last_d[0] = accept & i_last;
      for (int unsigned l = 1; l < LEVELS; l++) begin
        last_d[l] = last_q[l-1];
      end
      ov_d = 1'b0;
      if (vld_q[LEVELS-1]) begin
        if (last_q[LEVELS-1]) begin
          out_d = acc_sum;
          ov_d  = 1'b1;
          acc_d = '0;
        end else begin
          acc_d = acc_sum;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
      acc_q  <= '0;
      out_q  <= '0;
      ov_q   <= 1'b0;
    end else begin
      last_q <= last_d;
      acc_q  <= acc_d;
      out_q  <= out_d;
      ov_q   <= ov_d;
    end
  end
`else
  assign o_valid    = vld_q[LEVELS-1];
  assign o_data_bus = node_q[0];
`endif

endmodule
